mem_port_arbiter: RTL and testbench

Two-master, single-slave arbiter that shares one memory/bus port between the core's instruction-fetch interface and its load/store interface. It sits between `core_top` and the bus/console fabric. It replaces the separate ROM and RAM ports with one variable-latency request/ack slave port. It returns per-master stall requests so `pipe_ctrl` can freeze the pipeline while a master waits.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/arb_timeout_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    // Read data returned to a master whose transaction was aborted by timeout.
    localparam int ARB_ERR_RDATA    = 0;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Loadable, clearable up-counter that flags when the last permitted wait cycle is reached.
module arb_timeout_ctr #(
    parameter int WIDTH = 8,
    parameter int LAST  = 254
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clr_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (inc_i) begin
            count <= count + 1'b1;
        end
    end

    assign expired_o = (count == WIDTH'(LAST));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one request/ack slave port between instruction fetch and load/store,
// with data priority bounded by a starvation limit and a slave timeout.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | port free; arbitrate between fetch and data requests
// ST_IF_BUSY | fetch transaction presented to slave, waiting for ack/timeout
// ST_DM_BUSY | data transaction presented to slave, waiting for ack/timeout
// ST_DONE    | one-cycle completion: owner ack pulse, bus_err on abort
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  if_ce_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    output logic                  if_stallreq_o,

    input  logic                  dm_ce_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_WIDTH-1:0] dm_addr_i,
    input  logic [DATA_WIDTH-1:0] dm_wdata_i,
    output logic [DATA_WIDTH-1:0] dm_rdata_o,
    output logic                  dm_ack_o,
    output logic                  dm_stallreq_o,

    output logic                  s_req_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    input  logic                  s_ack_i,

    output logic                  bus_err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ARB_ERR_RDATA);

    arb_state_t state, state_nxt;
    logic grant_dm, grant_if, complete, abort;
    logic busy, tmo_expired;
    logic owner_dm, err_q;
    logic [SW-1:0] starve_cnt;

    assign busy = (state == ST_IF_BUSY) || (state == ST_DM_BUSY);

    arb_timeout_ctr #(
        .WIDTH (TW),
        .LAST  (TIMEOUT - 1)
    ) u_tmo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (~busy),
        .load_i     (1'b0),
        .load_val_i ({TW{1'b0}}),
        .inc_i      (busy),
        .expired_o  (tmo_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dm_ce_i && (starve_cnt != STARVE_MAX)) begin
                    grant_dm  = 1'b1;
                    state_nxt = ST_DM_BUSY;
                end else if (if_ce_i) begin
                    grant_if  = 1'b1;
                    state_nxt = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_DM_BUSY: begin
                // Ack takes precedence over a timeout landing in the same cycle.
                if (s_ack_i) begin
                    complete  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (tmo_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt <= '0;
            owner_dm   <= 1'b0;
            err_q      <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else begin
            // grant_dm already implies starve_cnt is below the limit.
            if (state == ST_IDLE) begin
                if (!if_ce_i) begin
                    starve_cnt <= '0;
                end else if (grant_dm) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end else if (grant_if) begin
                    starve_cnt <= '0;
                end
            end
            if (grant_dm) begin
                owner_dm  <= 1'b1;
                err_q     <= 1'b0;
                s_we_o    <= dm_we_i;
                s_addr_o  <= dm_addr_i;
                s_wdata_o <= dm_wdata_i;
            end else if (grant_if) begin
                owner_dm  <= 1'b0;
                err_q     <= 1'b0;
                s_we_o    <= 1'b0;
                s_addr_o  <= if_addr_i;
            end
            if (complete) begin
                if (owner_dm) begin
                    dm_rdata_o <= s_rdata_i;
                end else begin
                    if_rdata_o <= s_rdata_i;
                end
            end else if (abort) begin
                err_q <= 1'b1;
                if (owner_dm) begin
                    dm_rdata_o <= ERR_RDATA;
                end else begin
                    if_rdata_o <= ERR_RDATA;
                end
            end
        end
    end

    assign s_req_o       = busy;
    assign if_ack_o      = (state == ST_DONE) && !owner_dm;
    assign dm_ack_o      = (state == ST_DONE) && owner_dm;
    assign bus_err_o     = (state == ST_DONE) && err_q;
    assign if_stallreq_o = if_ce_i & ~if_ack_o;
    assign dm_stallreq_o = dm_ce_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        if_stallreq_o;
    logic        dm_ce_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        dm_stallreq_o;
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [31:0] s_rdata_i;
    logic        s_ack_i;
    logic        bus_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4),
        .TIMEOUT      (255)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_ack_o      (if_ack_o),
        .if_stallreq_o (if_stallreq_o),
        .dm_ce_i       (dm_ce_i),
        .dm_we_i       (dm_we_i),
        .dm_addr_i     (dm_addr_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_rdata_o    (dm_rdata_o),
        .dm_ack_o      (dm_ack_o),
        .dm_stallreq_o (dm_stallreq_o),
        .s_req_o       (s_req_o),
        .s_we_o        (s_we_o),
        .s_addr_o      (s_addr_o),
        .s_wdata_o     (s_wdata_o),
        .s_rdata_i     (s_rdata_i),
        .s_ack_i       (s_ack_i),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model state for the randomized phase
    localparam int LIMIT = 4;
    logic [31:0] mem [logic [31:0]];
    int          phase;
    int          m_starve;
    int          slave_wait;
    logic        first_cyc;
    logic        if_pend, dm_pend;
    logic [31:0] m_if_addr, m_dm_addr, m_dm_wdata;
    logic        m_dm_we;
    logic        txn_dm, txn_we;
    logic [31:0] txn_addr, txn_wdata, exp_rdata;
    logic        g_dm, g_if, exp_if_ack, exp_dm_ack;
    logic [5:0]  starve_seq;
    int          n;

    initial begin
        rst_i = 1'b0;
        if_ce_i = 1'b0; if_addr_i = '0;
        dm_ce_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        s_rdata_i = '0; s_ack_i = 1'b0;

        // Reset state
        cyc(); cyc();
        chk_b("rst_req", s_req_o, 1'b0);
        chk_b("rst_we", s_we_o, 1'b0);
        chk("rst_addr", s_addr_o, 32'h0);
        chk("rst_wdata", s_wdata_o, 32'h0);
        chk_b("rst_if_ack", if_ack_o, 1'b0);
        chk_b("rst_dm_ack", dm_ack_o, 1'b0);
        chk_b("rst_err", bus_err_o, 1'b0);
        chk("rst_if_rdata", if_rdata_o, 32'h0);
        chk("rst_dm_rdata", dm_rdata_o, 32'h0);
        rst_i = 1'b1;

        // Fetch only, zero-wait slave
        cyc();
        if_ce_i = 1'b1; if_addr_i = 32'h100; settle();
        chk_b("f_stall0", if_stallreq_o, 1'b1);
        chk_b("f_req0", s_req_o, 1'b0);
        cyc(); settle();
        chk_b("f_req1", s_req_o, 1'b1);
        chk_b("f_we1", s_we_o, 1'b0);
        chk("f_addr1", s_addr_o, 32'h100);
        s_ack_i = 1'b1; s_rdata_i = 32'h0000_0013;
        cyc(); s_ack_i = 1'b0; s_rdata_i = '0; settle();
        chk_b("f_ack2", if_ack_o, 1'b1);
        chk("f_rdata2", if_rdata_o, 32'h13);
        chk_b("f_stall2", if_stallreq_o, 1'b0);
        chk_b("f_req2", s_req_o, 1'b0);
        cyc(); if_ce_i = 1'b0; settle();
        chk_b("f_ack3", if_ack_o, 1'b0);
        chk("f_rdata_hold", if_rdata_o, 32'h13);

        // Simultaneous: data write with 3 wait states wins, then fetch
        cyc();
        if_ce_i = 1'b1; if_addr_i = 32'h104;
        dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h2000; dm_wdata_i = 32'hA5A5_A5A5;
        settle();
        for (int i = 1; i <= 4; i++) begin
            cyc(); settle();
            chk_b("s_req", s_req_o, 1'b1);
            chk_b("s_we", s_we_o, 1'b1);
            chk("s_addr", s_addr_o, 32'h2000);
            chk("s_wdata", s_wdata_o, 32'hA5A5_A5A5);
            chk_b("s_if_stall", if_stallreq_o, 1'b1);
            if (i == 4) begin
                s_ack_i = 1'b1; s_rdata_i = 32'h0BAD_0001;
            end
        end
        cyc(); s_ack_i = 1'b0; settle();
        chk_b("s_dm_ack", dm_ack_o, 1'b1);
        chk_b("s_dm_stall", dm_stallreq_o, 1'b0);
        chk_b("s_if_stall_d", if_stallreq_o, 1'b1);
        chk_b("s_if_ack_d", if_ack_o, 1'b0);
        cyc(); dm_ce_i = 1'b0; dm_we_i = 1'b0; settle();
        chk_b("s_idle_req", s_req_o, 1'b0);
        cyc(); settle();
        chk_b("s_if_req", s_req_o, 1'b1);
        chk_b("s_if_we", s_we_o, 1'b0);
        chk("s_if_addr", s_addr_o, 32'h104);
        s_ack_i = 1'b1; s_rdata_i = 32'hCAFE_0001;
        cyc(); s_ack_i = 1'b0; settle();
        chk_b("s_if_ack", if_ack_o, 1'b1);
        chk("s_if_rdata", if_rdata_o, 32'hCAFE_0001);
        chk("s_dm_rdata_hold", dm_rdata_o, 32'h0BAD_0001);
        cyc(); if_ce_i = 1'b0; settle();

        // Starvation: 4 data grants, then fetch, then data again after counter clears
        starve_seq = 6'b101111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if_ce_i = 1'b1; if_addr_i = 32'h400;
            dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
            settle();
            cyc(); settle();
            chk_b("st_req", s_req_o, 1'b1);
            chk("st_addr", s_addr_o, starve_seq[k] ? 32'h500 : 32'h400);
            s_ack_i = 1'b1; s_rdata_i = 32'h5000 + 32'(k);
            cyc(); s_ack_i = 1'b0; settle();
            chk_b("st_dm_ack", dm_ack_o, starve_seq[k]);
            chk_b("st_if_ack", if_ack_o, ~starve_seq[k]);
        end
        cyc(); if_ce_i = 1'b0; dm_ce_i = 1'b0; settle();

        // Timeout: slave never acks a data read
        cyc();
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000; settle();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(); settle();
            if (!s_req_o) break;
            n++;
        end
        chk("tmo_len", n, 32'd255);
        chk_b("tmo_ack", dm_ack_o, 1'b1);
        chk_b("tmo_err", bus_err_o, 1'b1);
        chk("tmo_rdata", dm_rdata_o, 32'h0);
        cyc(); dm_ce_i = 1'b0; settle();
        chk_b("tmo_err_clr", bus_err_o, 1'b0);
        chk_b("tmo_ack_clr", dm_ack_o, 1'b0);

        // Ack coincides with the last wait cycle: ack wins
        cyc();
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3004; settle();
        for (int i = 1; i <= 255; i++) begin
            cyc(); settle();
            if (i == 255) begin
                chk_b("col_req", s_req_o, 1'b1);
                s_ack_i = 1'b1; s_rdata_i = 32'h1234;
            end
        end
        cyc(); s_ack_i = 1'b0; settle();
        chk_b("col_ack", dm_ack_o, 1'b1);
        chk_b("col_err", bus_err_o, 1'b0);
        chk("col_rdata", dm_rdata_o, 32'h1234);
        cyc(); dm_ce_i = 1'b0; settle();

        // Reset during a data wait
        cyc();
        dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3008; settle();
        cyc(); settle();
        chk_b("rm_req", s_req_o, 1'b1);
        cyc(); settle();
        #2 rst_i = 1'b0;
        #1;
        chk_b("rm_req_async", s_req_o, 1'b0);
        chk("rm_dm_rdata", dm_rdata_o, 32'h0);
        dm_ce_i = 1'b0;
        cyc(); settle();
        chk_b("rm_ack_a", dm_ack_o, 1'b0);
        cyc(); rst_i = 1'b1; settle();
        chk_b("rm_ack_b", dm_ack_o, 1'b0);
        chk_b("rm_req_b", s_req_o, 1'b0);
        cyc();
        if_ce_i = 1'b1; if_addr_i = 32'h108; settle();
        cyc(); settle();
        chk_b("rm_f_req", s_req_o, 1'b1);
        chk("rm_f_addr", s_addr_o, 32'h108);
        s_ack_i = 1'b1; s_rdata_i = 32'h93;
        cyc(); s_ack_i = 1'b0; settle();
        chk_b("rm_f_ack", if_ack_o, 1'b1);
        chk("rm_f_rdata", if_rdata_o, 32'h93);
        cyc(); if_ce_i = 1'b0; settle();

        // Randomized traffic against the transaction-level model
        phase = 0; m_starve = 0; slave_wait = 0; first_cyc = 1'b0;
        if_pend = 1'b0; dm_pend = 1'b0;
        m_if_addr = '0; m_dm_addr = '0; m_dm_wdata = '0; m_dm_we = 1'b0;
        txn_dm = 1'b0; txn_we = 1'b0; txn_addr = '0; txn_wdata = '0; exp_rdata = '0;
        for (int c = 0; c < 600; c++) begin
            cyc();
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend   = 1'b1;
                m_if_addr = 32'h1000 + ($urandom_range(0, 63) << 2);
            end
            if (!dm_pend && $urandom_range(0, 2) == 0) begin
                dm_pend    = 1'b1;
                m_dm_we    = 1'($urandom_range(0, 1));
                m_dm_addr  = 32'h8000 + ($urandom_range(0, 15) << 2);
                m_dm_wdata = $urandom;
            end
            s_ack_i = 1'b0; s_rdata_i = '0;
            if (phase == 1 && slave_wait == 0) begin
                s_ack_i = 1'b1;
                if (txn_we) s_rdata_i = $urandom;
                else s_rdata_i = mem.exists(txn_addr) ? mem[txn_addr] : ~txn_addr;
            end
            if_ce_i = if_pend; if_addr_i = m_if_addr;
            dm_ce_i = dm_pend; dm_we_i = m_dm_we; dm_addr_i = m_dm_addr; dm_wdata_i = m_dm_wdata;
            settle();

            exp_if_ack = (phase == 2) && !txn_dm;
            exp_dm_ack = (phase == 2) && txn_dm;
            chk_b("r_req", s_req_o, phase == 1);
            chk_b("r_if_ack", if_ack_o, exp_if_ack);
            chk_b("r_dm_ack", dm_ack_o, exp_dm_ack);
            chk_b("r_err", bus_err_o, 1'b0);
            chk_b("r_if_stall", if_stallreq_o, if_pend & ~exp_if_ack);
            if (phase == 1 && first_cyc) begin
                chk("r_addr", s_addr_o, txn_addr);
                chk_b("r_we", s_we_o, txn_we);
                if (txn_we) chk("r_wdata", s_wdata_o, txn_wdata);
            end
            if (phase == 2) begin
                if (txn_dm) chk("r_dm_rdata", dm_rdata_o, exp_rdata);
                else chk("r_if_rdata", if_rdata_o, exp_rdata);
            end

            case (phase)
                0: begin
                    g_dm = dm_pend && (m_starve < LIMIT);
                    g_if = !g_dm && if_pend;
                    if (!if_pend) m_starve = 0;
                    else if (g_dm) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                    else if (g_if) m_starve = 0;
                    if (g_dm || g_if) begin
                        phase      = 1;
                        first_cyc  = 1'b1;
                        txn_dm     = g_dm;
                        txn_we     = g_dm ? m_dm_we : 1'b0;
                        txn_addr   = g_dm ? m_dm_addr : m_if_addr;
                        txn_wdata  = m_dm_wdata;
                        slave_wait = $urandom_range(0, 3);
                    end
                end
                1: begin
                    first_cyc = 1'b0;
                    if (s_ack_i) begin
                        phase     = 2;
                        exp_rdata = s_rdata_i;
                        if (txn_we) mem[txn_addr] = txn_wdata;
                    end else begin
                        slave_wait--;
                    end
                end
                default: begin
                    phase = 0;
                    if (txn_dm) dm_pend = 1'b0;
                    else if_pend = 1'b0;
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
